stopwatch_core: RTL and testbench

Stopwatch control-and-count stage that sits directly downstream of the button debouncer. It consumes the debouncer's single-cycle press pulses to drive a STOP/RUN/CLEAR state machine. It also runs a prescaled centisecond/second/minute/hour counter chain. Its time outputs feed the FND display formatter.

---
 rtl/stopwatch_core.sv | 191 +++++++++++++++++++
 tb/tb_stopwatch_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core: STOP/RUN/CLEAR control FSM driven by debounced press
// pulses, plus a prescaled centisecond/second/minute/hour counter chain.
// Optional feature macro: LAP_HOLD_EN (lap snapshot/hold of the time outputs).
// DIV = CLK_FREQ_HZ / TICK_HZ must be at least 2.
module stopwatch_core #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
`ifdef LAP_HOLD_EN
  input  logic       i_btn_lap,
  output logic       o_lap_hold,
`endif
  output logic [6:0] o_msec,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_run,
  output logic [1:0] o_state
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0] msec_q, msec_d;
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic tick;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      msec_q  <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      msec_q  <= msec_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  // Next-state logic; clear has priority in STOP, run has priority in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (i_btn_clear)    state_d = ST_CLEAR;
        else if (i_btn_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_btn_run) state_d = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Prescaler and time cascade; STOP holds everything including the partial period
  always_comb begin
    presc_d = presc_q;
    msec_d  = msec_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick    = 1'b0;
    case (state_q)
      ST_RUN: begin
        tick    = (presc_q == PRE_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (msec_q == 7'd99) begin
            msec_d = '0;
            if (sec_q == 6'd59) begin
              sec_d = '0;
              if (min_q == 6'd59) begin
                min_d  = '0;
                hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
              end else begin
                min_d = min_q + 6'd1;
              end
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            msec_d = msec_q + 7'd1;
          end
        end
      end
      ST_CLEAR: begin
        presc_d = '0;
        msec_d  = '0;
        sec_d   = '0;
        min_d   = '0;
        hour_d  = '0;
      end
      default: ;
    endcase
  end

`ifdef LAP_HOLD_EN
  logic       hold_q, hold_d;
  logic [6:0] snap_msec_q, snap_msec_d;
  logic [5:0] snap_sec_q, snap_sec_d;
  logic [5:0] snap_min_q, snap_min_d;
  logic [4:0] snap_hour_q, snap_hour_d;

  // Lap hold registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q      <= 1'b0;
      snap_msec_q <= '0;
      snap_sec_q  <= '0;
      snap_min_q  <= '0;
      snap_hour_q <= '0;
    end else begin
      hold_q      <= hold_d;
      snap_msec_q <= snap_msec_d;
      snap_sec_q  <= snap_sec_d;
      snap_min_q  <= snap_min_d;
      snap_hour_q <= snap_hour_d;
    end
  end

  // Lap toggles hold in RUN (snapshotting on set); in STOP it only releases
  always_comb begin
    hold_d      = hold_q;
    snap_msec_d = snap_msec_q;
    snap_sec_d  = snap_sec_q;
    snap_min_d  = snap_min_q;
    snap_hour_d = snap_hour_q;
    case (state_q)
      ST_RUN: begin
        if (i_btn_lap) begin
          hold_d = ~hold_q;
          if (!hold_q) begin
            snap_msec_d = msec_q;
            snap_sec_d  = sec_q;
            snap_min_d  = min_q;
            snap_hour_d = hour_q;
          end
        end
      end
      ST_STOP: begin
        if (i_btn_lap) hold_d = 1'b0;
      end
      default: hold_d = 1'b0;
    endcase
  end

  // Outputs decoded from registers; snapshot shown while held
  always_comb begin
    o_run      = (state_q == ST_RUN);
    o_state    = state_q;
    o_lap_hold = hold_q;
    o_msec     = hold_q ? snap_msec_q : msec_q;
    o_sec      = hold_q ? snap_sec_q  : sec_q;
    o_min      = hold_q ? snap_min_q  : min_q;
    o_hour     = hold_q ? snap_hour_q : hour_q;
  end
`else
  // Outputs decoded from registers; time is always live
  always_comb begin
    o_run   = (state_q == ST_RUN);
    o_state = state_q;
    o_msec  = msec_q;
    o_sec   = sec_q;
    o_min   = min_q;
    o_hour  = hour_q;
  end
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: behavioural model (elapsed run cycles -> centiseconds
// of day), per-cycle comparison, directed literal checks, then random pulses.
// LAP_HOLD_EN, when defined, also exercises the lap hold feature.
module tb_stopwatch_core;

  localparam int CLK_HZ = 1000;
  localparam int TK_HZ  = 100;
  localparam int DIV    = CLK_HZ / TK_HZ;
  localparam int CS_DAY = 24 * 60 * 60 * 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run = 1'b0;
  logic clear = 1'b0;
`ifdef LAP_HOLD_EN
  logic lap = 1'b0;
  logic o_lap_hold;
`endif
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_run;
  logic [1:0] o_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit preload_req = 1'b0;

  // model state
  int m_state = 0;   // 0 stop, 1 run, 2 clear
  int m_pre = 0;     // run cycles since last completed centisecond
  int m_cs = 0;      // centiseconds of day
  bit m_hold = 1'b0;
  int m_snap = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TK_HZ)) dut (
    .clk(clk),
    .reset(reset),
    .i_btn_run(run),
    .i_btn_clear(clear),
`ifdef LAP_HOLD_EN
    .i_btn_lap(lap),
    .o_lap_hold(o_lap_hold),
`endif
    .o_msec(o_msec),
    .o_sec(o_sec),
    .o_min(o_min),
    .o_hour(o_hour),
    .o_run(o_run),
    .o_state(o_state)
  );

  // Reference model: advances on each rising edge from the sampled inputs
  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_pre = 0; m_cs = 0; m_hold = 1'b0; m_snap = 0;
    end else if (preload_req) begin
      m_cs = CS_DAY - 1;
    end else begin
      case (m_state)
        0: begin
`ifdef LAP_HOLD_EN
          if (lap) m_hold = 1'b0;
`endif
          if (clear) m_state = 2;
          else if (run) m_state = 1;
        end
        1: begin
`ifdef LAP_HOLD_EN
          if (lap) begin
            if (m_hold) m_hold = 1'b0;
            else begin m_hold = 1'b1; m_snap = m_cs; end
          end
`endif
          m_pre = m_pre + 1;
          if (m_pre == DIV) begin
            m_pre = 0;
            m_cs = (m_cs + 1) % CS_DAY;
          end
          if (run) m_state = 0;
        end
        default: begin
          m_pre = 0; m_cs = 0; m_hold = 1'b0; m_state = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      int e, e_ms, e_s, e_m, e_h;
      bit ok;
      e = m_hold ? m_snap : m_cs;
      e_ms = e % 100;
      e_s = (e / 100) % 60;
      e_m = (e / 6000) % 60;
      e_h = e / 360000;
      ok = (o_msec === 7'(e_ms)) && (o_sec === 6'(e_s)) && (o_min === 6'(e_m)) &&
           (o_hour === 5'(e_h)) && (o_state === 2'(m_state)) &&
           (o_run === (m_state == 1));
`ifdef LAP_HOLD_EN
      ok = ok && (o_lap_hold === m_hold);
`endif
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: got %0d:%0d:%0d.%0d run=%0d st=%0d, want %0d:%0d:%0d.%0d run=%0d st=%0d",
                 $time, o_hour, o_min, o_sec, o_msec, o_run, o_state,
                 e_h, e_m, e_s, e_ms, (m_state == 1), m_state);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit r, input bit c);
    run = r; clear = c;
    step(1);
    run = 1'b0; clear = 1'b0;
  endtask

`ifdef LAP_HOLD_EN
  task automatic pulse_lap();
    lap = 1'b1;
    step(1);
    lap = 1'b0;
  endtask
`endif

  // Load 23:59:59.99 into the counters while stopped
  task automatic preload_last();
    chk_en = 1'b0;
    force dut.msec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    force dut.hour_q = 5'd23;
    preload_req = 1'b1;
    step(1);
    release dut.msec_q;
    release dut.sec_q;
    release dut.min_q;
    release dut.hour_q;
    preload_req = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(2);
    reset = 1'b0;

    // idle after reset: nothing counts
    step(50);
    check("rst_state", o_state, 0);
    check("rst_run", o_run, 0);
    check("rst_msec", o_msec, 0);
    check("rst_sec", o_sec, 0);
    check("rst_hour", o_hour, 0);

    // first tick DIV cycles after RUN entry, then 1000 cycles -> 1 s
    pulse(1, 0);
    check("run_entry", o_run, 1);
    step(9);
    check("pre_tick_msec", o_msec, 0);
    step(1);
    check("first_tick_msec", o_msec, 1);
    step(990);
    check("1s_msec", o_msec, 0);
    check("1s_sec", o_sec, 1);
    pulse(1, 0);
    check("stopped", o_state, 0);

    // clear: one cycle in CLEAR, zeroed afterwards
    pulse(0, 1);
    check("clear_state", o_state, 2);
    step(1);
    check("after_clear_state", o_state, 0);
    check("after_clear_sec", o_sec, 0);

    // partial prescaler period survives a stop
    pulse(1, 0);
    step(4);
    pulse(1, 0);
    step(100);
    check("held_msec", o_msec, 0);
    pulse(1, 0);
    step(4);
    check("resume_pre_msec", o_msec, 0);
    step(1);
    check("resume_msec", o_msec, 1);
    pulse(1, 0);

    // both pulses in STOP: clear wins
    pulse(1, 1);
    check("both_stop_state", o_state, 2);
    step(1);
    check("both_stop_after", o_state, 0);
    check("both_stop_msec", o_msec, 0);

    // both pulses in RUN: run wins, counters keep value
    pulse(1, 0);
    step(34);
    pulse(1, 1);
    check("both_run_state", o_state, 0);
    check("both_run_msec", o_msec, 3);
    step(2);
    check("both_run_keep", o_msec, 3);

`ifdef LAP_HOLD_EN
    // lap snapshot at 3, live count reaches 53 while held
    pulse(0, 1);
    step(1);
    pulse(1, 0);
    step(34);
    pulse_lap();
    check("lap_hold_set", o_lap_hold, 1);
    step(499);
    check("lap_frozen_msec", o_msec, 3);
    pulse_lap();
    check("lap_release_hold", o_lap_hold, 0);
    check("lap_live_msec", o_msec, 53);
    pulse(1, 0);
`endif

    // full-day wrap from 23:59:59.99
    pulse(0, 1);
    step(1);
    preload_last();
    pulse(1, 0);
    step(9);
    check("pre_wrap_hour", o_hour, 23);
    check("pre_wrap_msec", o_msec, 99);
    step(1);
    check("wrap_msec", o_msec, 0);
    check("wrap_sec", o_sec, 0);
    check("wrap_min", o_min, 0);
    check("wrap_hour", o_hour, 0);
    pulse(1, 0);

    // random pulses, including back-to-back and coincident ones, and resets
    for (int i = 0; i < 5000; i++) begin
      run   = ($urandom_range(0, 29) == 0);
      clear = ($urandom_range(0, 89) == 0);
      reset = ($urandom_range(0, 999) == 0);
`ifdef LAP_HOLD_EN
      lap   = ($urandom_range(0, 24) == 0);
`endif
      step(1);
    end
    run = 1'b0; clear = 1'b0; reset = 1'b0;
`ifdef LAP_HOLD_EN
    lap = 1'b0;
`endif
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
